// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

  // Opcodes 9..14 are unnamed and, like OP_ILL, are treated as illegal.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8,
    OP_ILL = 4'd15
  } op_e;

  // Bit positions inside the {Z,N,C,V} flag vector.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: opcodes 0..7 with flags; anything else
// (including MUL, which is handled sequentially) yields result 0, flags 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic             c;
  logic             v;
  logic             valid_op;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  // Select the result and carry/overflow for the requested operation.
  always_comb begin
    res      = '0;
    c        = 1'b0;
    v        = 1'b0;
    valid_op = 1'b1;
    case (op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        // The extra top bit of the difference is the unsigned borrow.
        c   = diff[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SHL: res = a << shamt;
      OP_SHR: res = a >> shamt;
      default: valid_op = 1'b0;
    endcase
  end

  // Assemble {Z,N,C,V}; non-single-cycle opcodes report all flags clear.
  always_comb begin
    flags = '0;
    if (valid_op) begin
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_N] = res[WIDTH-1];
      flags[FLAG_C] = c;
      flags[FLAG_V] = v;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready flow control on both sides. Single-cycle
// and illegal ops complete on the accepting edge; MUL runs a WIDTH-cycle
// shift-add multiplier. Outputs are registered and held under backpressure.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  state_e             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   core_res;
  logic [3:0]         core_flags;
  logic [3:0]         mul_flags;
  logic               accept;

  // A finished result frees the output register in the same cycle it is taken.
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (op),
    .a     (a),
    .b     (b),
    .res   (core_res),
    .flags (core_flags)
  );

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit (LSB first) is set.
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
  end

  // MUL flags from the final accumulated product.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (acc_nxt[WIDTH-1:0] == '0);
    mul_flags[FLAG_N] = acc_nxt[WIDTH-1];
    mul_flags[FLAG_C] = (acc_nxt[2*WIDTH-1:WIDTH] != '0);
  end

  // Control FSM, multiplier datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      result    <= '0;
      flags     <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              acc       <= '0;
              mcand     <= {{WIDTH{1'b0}}, a};
              mplier    <= b;
              cnt       <= WIDTH'(WIDTH);
              out_valid <= 1'b0;
              state     <= S_BUSY;
            end else begin
              // alu_core already returns zero result/flags for illegal codes.
              result    <= core_res;
              flags     <= core_flags;
              err       <= !op_is_legal(op);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end else if ((state == S_DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - WIDTH'(1);
          if (cnt == WIDTH'(1)) begin
            result    <= acc_nxt[WIDTH-1:0];
            flags     <= mul_flags;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU. Registers one operation per valid/ready transaction and returns a registered result plus a Z/N/C/V flag set and an error bit. It succeeds the 8-bit combinational ALU in the processor datapath. It adds configurable width, shifts, a sequential shift-add multiplier, and flow control on both sides so the execute stage can stall it or be stalled by it.

## Interface
Parameters:
- WIDTH, 8, operand and result width; power of two, at least 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- op  input  4  opcode (encoding under Operation)
- a, b  input  WIDTH  operands, unsigned unless noted
- out_valid  output  1  result, flags and err are valid
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  registered result
- flags  output  4  {Z,N,C,V}, registered
- err  output  1  the delivered operation used an illegal opcode

## Operation
- Opcodes:
  - 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SHL: a << b[log2(WIDTH)−1:0]; 7 SHR: logical right shift by the same amount.
  - 8 MUL: low WIDTH bits of a*b.
  - 9–15 illegal: result 0, flags 0, err 1.
- Flags:
  - Z = (result==0). N = result[WIDTH−1].
  - ADD: C = carry out, V = signed overflow.
  - SUB: C = borrow (a<b unsigned), V = signed overflow.
  - MUL: C = 1 if the upper WIDTH bits of the full product are nonzero; V=0.
  - Logic ops and shifts: C=0, V=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On accept (in_valid & in_ready), a MUL goes to BUSY; every other op computes, registers its outputs and goes to DONE.
  - BUSY: in_ready=0. Shift-add multiplier consumes one bit of b per cycle, LSB first, over exactly WIDTH cycles using a WIDTH-bit down-counter, then goes to DONE.
  - DONE: out_valid=1. in_ready = out_ready.
    - out_ready & in_valid: consume the result and accept the new op in the same cycle (back-to-back).
    - out_ready & !in_valid: go to IDLE.
    - !out_ready: hold.
- Operands and op are captured on accept. Input changes after accept have no effect.
- result, flags and err stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: state IDLE, result 0, flags 0, err 0, out_valid 0, counter 0. in_ready is 1 whenever state is IDLE. Inputs are ignored while rst is high.
- Single-cycle ops and illegal ops: accept at edge E, out_valid=1 after E (latency 1).
- MUL: accept at E, out_valid=1 after edge E+WIDTH (latency WIDTH). in_ready=0 for the WIDTH intervening cycles.
- Sustained throughput: one single-cycle op per clock when out_ready is held high.
- Reset asserted mid-MUL or in DONE: the operation is discarded and the result is never delivered. Outputs return to reset values immediately (asynchronous).
- out_ready with out_valid=0: ignored.
- All outputs are registered except in_ready, which is a combinational function of state and out_ready.

## Structure
- Shared package alu_pkg: op_e enum (10 named opcodes plus illegal range), flag bit index constants (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0), state_e enum.
- Sub-module alu_core: purely combinational single-cycle ops (0–7) and their flags, parametrised by WIDTH.
- FSM, MUL datapath (accumulator, multiplicand shift register, counter) and output registers live in alu_mc.

## Test plan
(WIDTH=8)
- ADD 0xFF+0x01, out_ready=1 → after 1 edge: result 0x00, flags Z=1 N=0 C=1 V=0, err 0. SUB 0x80−0x01 → 0x7F, V=1, C=0. SUB 0x00−0x01 → 0xFF, N=1, C=1.
- MUL 0x0F*0x11 → 0xFF, C=0, out_valid exactly 8 edges after accept, in_ready=0 throughout BUSY. MUL 0x10*0x10 → result 0x00, Z=1, C=1.
- SHL 0x81 by b=0x09 (shift amount 1) → 0x02. SHR 0x80 by 7 → 0x01. Logic op: NOR 0xF0,0x0F → 0x00, Z=1.
- Backpressure: ADD completes, out_ready held 0 for 3 cycles while a, b, op toggle → result and flags unchanged and in_ready=0. Then out_ready=1 with in_valid=1 and XOR 0xAA,0x55 → XOR is accepted the same cycle and result 0xFF appears on the next edge.
- Reset pulse at BUSY cycle 4 of a MUL → out_valid stays 0 and outputs stay 0. After release, in_ready=1 and a new ADD 2+3 returns 0x05.
- op=0xC with a=0x12, b=0x34 → result 0x00, flags 0, err=1, latency 1. The next legal op returns err=0.
